xor4_vector_sequencer: RTL and testbench
========================================

# xor4_vector_sequencer

Self-checking stimulus controller for the four-input XOR datapath (`exercise4_3`). It holds a small writable table of test vectors, each a 4-bit input plus the expected output. On `start` it applies the vectors to the datapath one at a time, waits a programmable settle time, samples `y`, and counts mismatches. It replaces testbench-only `$readmemb` sequencing with synthesizable hardware, so the same check runs on the board.

## Interface
Parameters:
- `DEPTH`, 16: number of vector entries; fixed at 16 for a 4-bit address.
- `SETTLE`, 1: cycles between applying a vector and sampling `dut_y`; legal range 1..15.

Ports:
- `clk`  in  1  single clock, rising-edge.
- `reset`  in  1  synchronous, active-high.
- `wr_en`  in  1  vector-table write strobe.
- `wr_addr`  in  4  table entry index.
- `wr_data`  in  5  `{a[3:0], yexpected}`.
- `start`  in  1  begin a run; sampled only in IDLE.
- `abort`  in  1  terminate a run; sampled only in WAIT/CHECK.
- `num_vec`  in  5  vectors to run, latched at start; values >16 clamp to 16.
- `dut_a`  out  4  registered datapath input.
- `dut_y`  in  1  datapath output.
- `busy`  out  1  high in WAIT and CHECK.
- `done`  out  1  one-cycle pulse at end of a completed run.
- `pass`  out  1  high when the last completed run had 0 errors.
- `err_count`  out  5  mismatches in the current or last run (0..16).
- `first_err_idx`  out  4  index of the first mismatching vector.
- `first_err_valid`  out  1  `first_err_idx` is meaningful.

## Operation
- Vector table: 16×5 register array with no reset; contents are X until written. Reads are combinational by index.
- Writes are accepted only when `busy`=0; writes while busy are dropped.
- States and transitions:
  - IDLE →(start) WAIT, or →(start, num_vec=0) DONE.
  - WAIT →(settle count=0) CHECK.
  - CHECK →(last vector) DONE; otherwise → WAIT.
  - DONE → IDLE unconditionally.
  - WAIT/CHECK →(abort) IDLE.
- Start edge (IDLE, start=1):
  - Latch `n = min(num_vec, 16)`.
  - Set idx=0, err_count=0, first_err_valid=0, first_err_idx=0, pass=0.
  - If n>0: load `dut_a` and the internal expected bit from entry 0, and load the settle counter with SETTLE-1.
- WAIT: decrement the settle counter; move to CHECK when it is 0.
- CHECK edge:
  - If `dut_y` ≠ expected: increment err_count. If first_err_valid=0, record idx in first_err_idx and set first_err_valid.
  - If idx = n-1: go to DONE.
  - Otherwise: idx+1, load `dut_a`/expected from entry idx+1, reload the settle counter, go to WAIT.
- DONE: `done`=1 for this cycle. `pass` is set at the DONE entry edge to (err_count_final = 0).
- Abort: return to IDLE on the next edge. No `done` pulse; `pass` stays 0. err_count and first_err_* keep their partial values; `dut_a` holds its last value.
- err_count, first_err_*, pass and `dut_a` hold until the next start or reset.

## Timing
- Reset values: state IDLE, `dut_a`=0, busy=0, done=0, pass=0, err_count=0, first_err_idx=0, first_err_valid=0, idx=0. The table is not cleared.
- Start sampled at edge N: busy=1 from N; `dut_a` shows vector 0 from N.
- Vector k is compared at edge N + (k+1)(SETTLE+1). It is on `dut_a` for exactly SETTLE+1 cycles.
- Last compare at edge N + n(SETTLE+1); done=1 in the following cycle, busy=0 in that cycle.
- Total run: n(SETTLE+1)+1 cycles including the DONE cycle.
- num_vec=0: start edge N → DONE; done=1 and pass=1 in the cycle after N; `dut_a` unchanged.
- start while busy or in DONE: ignored.
- start and wr_en in the same IDLE cycle: the write lands; the run reads entry 0 as it was before the write.
- abort and last CHECK on the same edge: abort wins, no done.
- start and abort together in IDLE: start wins.
- Reset mid-run: all outputs return to reset values at that edge; no done pulse.

## Test plan
- Reset; write all 16 correct XOR4 vectors (entry i = {i, ^i}); SETTLE=1, num_vec=16, start at edge N, real XOR4 attached → done high in the cycle after edge N+32, pass=1, err_count=0, first_err_valid=0; `dut_a` steps 0..15 every 2 cycles.
- Same table but entries 5 and 9 carry inverted expected bits → err_count=2, first_err_idx=5, first_err_valid=1, pass=0.
- num_vec=0, start → done the next cycle, pass=1, err_count=0, busy never high; num_vec=20 → exactly 16 vectors are applied.
- SETTLE=3, num_vec=4 → each vector is held 4 cycles, done at edge N+16 +1 cycle; start pulsed at vector 2 is ignored; wr_en at vector 2 leaves the table unchanged on readback.
- Abort asserted during vector 7 WAIT → busy=0 next cycle, no done, pass=0, err_count keeps its partial value; a fresh start then completes normally.
- Reset asserted during vector 7 CHECK → all outputs at reset values next cycle, no done pulse; the table still holds the written vectors.

Source files
------------

// File: rtl/xor4_vector_sequencer_if.sv
// Control and status bundle for the XOR4 vector sequencer: table writes,
// run control and run results.
interface xor4_vector_sequencer_if;
    logic       wr_en;
    logic [3:0] wr_addr;
    logic [4:0] wr_data;
    logic       start;
    logic       abort;
    logic [4:0] num_vec;
    logic       busy;
    logic       done;
    logic       pass;
    logic [4:0] err_count;
    logic [3:0] first_err_idx;
    logic       first_err_valid;

    modport master (
        output wr_en, wr_addr, wr_data, start, abort, num_vec,
        input  busy, done, pass, err_count, first_err_idx, first_err_valid
    );

    modport slave (
        input  wr_en, wr_addr, wr_data, start, abort, num_vec,
        output busy, done, pass, err_count, first_err_idx, first_err_valid
    );
endinterface

// File: rtl/xor4_vector_sequencer.sv
// Applies stored {a, yexpected} vectors to the XOR4 datapath, samples dut_y
// after a settle delay and tallies mismatches.
module xor4_vector_sequencer #(
    parameter int DEPTH  = 16,
    parameter int SETTLE = 1
) (
    input  logic                      clk,
    input  logic                      reset,
    xor4_vector_sequencer_if.slave    bus,
    output logic [3:0]                dut_a,
    input  logic                      dut_y
);
    typedef enum logic [1:0] {IDLE, WAIT, CHECK, DONE} state_t;

    localparam logic [3:0] SETTLE_LOAD = 4'(SETTLE - 1);

    state_t     state;
    logic [4:0] vec_table [DEPTH];
    logic [4:0] n_q;
    logic [3:0] idx_q;
    logic       exp_q;
    logic [3:0] settle_q;

    logic [4:0] n_start;
    logic       mismatch;
    logic [4:0] err_next;
    logic       last;
    logic [4:0] next_entry;

    always_comb begin
        n_start    = (bus.num_vec > 5'd16) ? 5'd16 : bus.num_vec;
        mismatch   = (dut_y != exp_q);
        err_next   = bus.err_count + {4'b0, mismatch};
        last       = ({1'b0, idx_q} == (n_q - 5'd1));
        next_entry = vec_table[idx_q + 4'd1];
    end

    // Table has no reset so written vectors survive a mid-run reset.
    always_ff @(posedge clk) begin
        if (bus.wr_en && !bus.busy)
            vec_table[bus.wr_addr] <= bus.wr_data;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state               <= IDLE;
            dut_a               <= '0;
            bus.busy            <= 1'b0;
            bus.done            <= 1'b0;
            bus.pass            <= 1'b0;
            bus.err_count       <= '0;
            bus.first_err_idx   <= '0;
            bus.first_err_valid <= 1'b0;
            n_q                 <= '0;
            idx_q               <= '0;
            exp_q               <= 1'b0;
            settle_q            <= '0;
        end else begin
            bus.done <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        n_q                 <= n_start;
                        idx_q               <= '0;
                        bus.err_count       <= '0;
                        bus.first_err_valid <= 1'b0;
                        bus.first_err_idx   <= '0;
                        bus.pass            <= 1'b0;
                        if (n_start == 5'd0) begin
                            state    <= DONE;
                            bus.done <= 1'b1;
                            bus.pass <= 1'b1;
                        end else begin
                            dut_a    <= vec_table[0][4:1];
                            exp_q    <= vec_table[0][0];
                            settle_q <= SETTLE_LOAD;
                            bus.busy <= 1'b1;
                            state    <= WAIT;
                        end
                    end
                end
                WAIT: begin
                    if (bus.abort) begin
                        state    <= IDLE;
                        bus.busy <= 1'b0;
                    end else if (settle_q == 4'd0) begin
                        state <= CHECK;
                    end else begin
                        settle_q <= settle_q - 4'd1;
                    end
                end
                CHECK: begin
                    // Abort outranks the compare, so the aborted sample is not counted.
                    if (bus.abort) begin
                        state    <= IDLE;
                        bus.busy <= 1'b0;
                    end else begin
                        bus.err_count <= err_next;
                        if (mismatch && !bus.first_err_valid) begin
                            bus.first_err_idx   <= idx_q;
                            bus.first_err_valid <= 1'b1;
                        end
                        if (last) begin
                            state    <= DONE;
                            bus.busy <= 1'b0;
                            bus.done <= 1'b1;
                            bus.pass <= (err_next == 5'd0);
                        end else begin
                            idx_q    <= idx_q + 4'd1;
                            dut_a    <= next_entry[4:1];
                            exp_q    <= next_entry[0];
                            settle_q <= SETTLE_LOAD;
                            state    <= WAIT;
                        end
                    end
                end
                DONE: state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_xor4_vector_sequencer.sv
// Scoreboard bench: two sequencers (SETTLE=1 and SETTLE=3), each driving a
// behavioural XOR4; run results are queued at start and checked on done.
module tb_xor4_vector_sequencer;
    logic       clk;
    logic       reset;
    logic [3:0] a1, a3;
    logic       y1, y3;
    int         cyc = 0;
    int         checks = 0;
    int         passes = 0;

    typedef struct {
        int at;
        int err;
        int fidx;
        int fv;
        int pass;
    } exp_t;

    exp_t q1[$];
    exp_t q3[$];

    xor4_vector_sequencer_if b1();
    xor4_vector_sequencer_if b3();

    xor4_vector_sequencer #(.DEPTH(16), .SETTLE(1)) u1 (
        .clk(clk), .reset(reset), .bus(b1), .dut_a(a1), .dut_y(y1)
    );
    xor4_vector_sequencer #(.DEPTH(16), .SETTLE(3)) u3 (
        .clk(clk), .reset(reset), .bus(b3), .dut_a(a3), .dut_y(y3)
    );

    assign y1 = ^a1;
    assign y3 = ^a3;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act == exp) passes++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    task automatic compare_run(input string tag, input exp_t e, input int err,
                               input int fidx, input int fv, input int pass);
        chk({tag, "_done_edge"}, cyc, e.at);
        chk({tag, "_err_count"}, err, e.err);
        chk({tag, "_first_err_valid"}, fv, e.fv);
        if (e.fv != 0) chk({tag, "_first_err_idx"}, fidx, e.fidx);
        chk({tag, "_pass"}, pass, e.pass);
    endtask

    // Monitor: every done pulse must match the oldest queued expectation.
    always @(negedge clk) begin
        exp_t e;
        if (b1.done) begin
            if (q1.size() == 0) chk("s1_unexpected_done", 1, 0);
            else begin
                e = q1.pop_front();
                compare_run("s1", e, b1.err_count, b1.first_err_idx, b1.first_err_valid, b1.pass);
            end
        end
        if (b3.done) begin
            if (q3.size() == 0) chk("s3_unexpected_done", 1, 0);
            else begin
                e = q3.pop_front();
                compare_run("s3", e, b3.err_count, b3.first_err_idx, b3.first_err_valid, b3.pass);
            end
        end
    end

    task automatic drive(input bit s, input logic we, input logic [3:0] wa,
                         input logic [4:0] wd, input logic st, input logic ab,
                         input logic [4:0] nv);
        if (s) begin
            b3.wr_en = we; b3.wr_addr = wa; b3.wr_data = wd;
            b3.start = st; b3.abort = ab; b3.num_vec = nv;
        end else begin
            b1.wr_en = we; b1.wr_addr = wa; b1.wr_data = wd;
            b1.start = st; b1.abort = ab; b1.num_vec = nv;
        end
    endtask

    task automatic wr(input bit s, input logic [3:0] addr, input logic [4:0] data);
        @(negedge clk);
        drive(s, 1'b1, addr, data, 1'b0, 1'b0, 5'd0);
        @(negedge clk);
        drive(s, 1'b0, 4'd0, 5'd0, 1'b0, 1'b0, 5'd0);
    endtask

    // Returns at the negedge just after start edge N, with n_edge = N.
    task automatic start_run(input bit s, input logic [4:0] nv, output int n_edge);
        @(negedge clk);
        drive(s, 1'b0, 4'd0, 5'd0, 1'b1, 1'b0, nv);
        n_edge = cyc + 1;
        @(negedge clk);
        drive(s, 1'b0, 4'd0, 5'd0, 1'b0, 1'b0, 5'd0);
    endtask

    task automatic wait_done(input bit s, input int budget);
        bit seen;
        seen = s ? b3.done : b1.done;
        for (int i = 0; i < budget && !seen; i++) begin
            @(negedge clk);
            seen = s ? b3.done : b1.done;
        end
        chk("done_within_budget", int'(seen), 1);
    endtask

    task automatic write_good_table(input bit s, input int count);
        for (int i = 0; i < count; i++) begin
            logic [3:0] v;
            v = 4'(i);
            wr(s, v, {v, ^v});
        end
    endtask

    initial begin
        int n;
        reset = 1'b1;
        drive(1'b0, 1'b0, 4'd0, 5'd0, 1'b0, 1'b0, 5'd0);
        drive(1'b1, 1'b0, 4'd0, 5'd0, 1'b0, 1'b0, 5'd0);
        repeat (3) @(negedge clk);
        reset = 1'b0;

        chk("rst_dut_a", a1, 0);
        chk("rst_busy", b1.busy, 0);
        chk("rst_done", b1.done, 0);
        chk("rst_pass", b1.pass, 0);
        chk("rst_err_count", b1.err_count, 0);
        chk("rst_first_err_idx", b1.first_err_idx, 0);
        chk("rst_first_err_valid", b1.first_err_valid, 0);

        // Full good table, 16 vectors, each held 2 cycles.
        write_good_table(1'b0, 16);
        start_run(1'b0, 5'd16, n);
        q1.push_back('{n + 32, 0, 0, 0, 1});
        for (int k = 0; k < 32; k++) begin
            chk("s1_dut_a_step", a1, k / 2);
            chk("s1_busy_in_run", b1.busy, 1);
            @(negedge clk);
        end
        wait_done(1'b0, 4);
        chk("s1_busy_in_done", b1.busy, 0);

        // Entries 5 and 9 with inverted expected bits (^5 = 0, ^9 = 0).
        wr(1'b0, 4'd5, {4'd5, 1'b1});
        wr(1'b0, 4'd9, {4'd9, 1'b1});
        start_run(1'b0, 5'd16, n);
        q1.push_back('{n + 32, 2, 5, 1, 0});
        wait_done(1'b0, 40);

        // num_vec = 0: done immediately, never busy, dut_a untouched.
        start_run(1'b0, 5'd0, n);
        q1.push_back('{n, 0, 0, 0, 1});
        chk("nv0_busy", b1.busy, 0);
        chk("nv0_dut_a_hold", a1, 15);
        wait_done(1'b0, 2);

        // num_vec = 20 clamps to 16.
        start_run(1'b0, 5'd20, n);
        q1.push_back('{n + 32, 2, 5, 1, 0});
        wait_done(1'b0, 40);

        // Abort during vector 7 WAIT (after edge N+14).
        start_run(1'b0, 5'd16, n);
        repeat (14) @(negedge clk);
        drive(1'b0, 1'b0, 4'd0, 5'd0, 1'b0, 1'b1, 5'd0);
        @(negedge clk);
        drive(1'b0, 1'b0, 4'd0, 5'd0, 1'b0, 1'b0, 5'd0);
        chk("abort_busy", b1.busy, 0);
        chk("abort_pass", b1.pass, 0);
        chk("abort_err_count", b1.err_count, 1);
        chk("abort_first_err_idx", b1.first_err_idx, 5);
        chk("abort_first_err_valid", b1.first_err_valid, 1);
        chk("abort_dut_a_hold", a1, 7);
        repeat (20) @(negedge clk);
        chk("abort_no_done_queue", q1.size(), 0);
        start_run(1'b0, 5'd16, n);
        q1.push_back('{n + 32, 2, 5, 1, 0});
        wait_done(1'b0, 40);

        // Reset during vector 7 CHECK (after edge N+15).
        start_run(1'b0, 5'd16, n);
        repeat (15) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("mrst_dut_a", a1, 0);
        chk("mrst_busy", b1.busy, 0);
        chk("mrst_done", b1.done, 0);
        chk("mrst_pass", b1.pass, 0);
        chk("mrst_err_count", b1.err_count, 0);
        chk("mrst_first_err_idx", b1.first_err_idx, 0);
        chk("mrst_first_err_valid", b1.first_err_valid, 0);
        repeat (20) @(negedge clk);
        start_run(1'b0, 5'd16, n);
        q1.push_back('{n + 32, 2, 5, 1, 0});
        wait_done(1'b0, 40);

        // SETTLE=3: 4 vectors held 4 cycles; start and write at vector 2 ignored.
        write_good_table(1'b1, 4);
        start_run(1'b1, 5'd4, n);
        q3.push_back('{n + 16, 0, 0, 0, 1});
        for (int k = 0; k < 16; k++) begin
            chk("s3_dut_a_hold", a3, k / 4);
            if (k == 8) drive(1'b1, 1'b1, 4'd0, 5'b00001, 1'b1, 1'b0, 5'd1);
            else        drive(1'b1, 1'b0, 4'd0, 5'd0, 1'b0, 1'b0, 5'd0);
            @(negedge clk);
        end
        wait_done(1'b1, 4);
        start_run(1'b1, 5'd4, n);
        q3.push_back('{n + 16, 0, 0, 0, 1});
        wait_done(1'b1, 24);

        repeat (4) @(negedge clk);
        chk("s1_queue_drained", q1.size(), 0);
        chk("s3_queue_drained", q3.size(), 0);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
